k2_program_memory: RTL and testbench
====================================

Name: k2_program_memory

Overview:
Parametrised, writable multi-bank program store for the K2 processor. It supersedes fixed hard-coded program ROMs. An external loader streams a program into any bank through a valid/ready handshake. The processor fetches from a selected bank with a registered one-cycle read. Entries that have not been written read back as a fill opcode, and the processor is held while its own bank is being reloaded.

Parameters:
DATA_W, 8, instruction width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries per bank
BANKS, 2, number of independent program banks; BANK_W = max(1, clog2(BANKS))
FILL, 8'h00, value returned for unwritten entries and for out-of-range banks

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
rd_en  input  1  fetch request
rd_bank  input  BANK_W  bank the processor executes from
rd_addr  input  ADDR_W  fetch address (processor step counter)
inst  output  DATA_W  fetched instruction, registered
inst_valid  output  1  one-cycle pulse; inst updated this cycle
ld_start  input  1  pulse; begin loading bank ld_bank
ld_bank  input  BANK_W  bank to load, sampled on ld_start
ld_valid  input  1  load beat valid
ld_data  input  DATA_W  load beat data
ld_last  input  1  final beat of program, qualified by ld_valid
ld_ready  output  1  block accepts load beats
ld_busy  output  1  load in progress
ld_count  output  ADDR_W+1  beats accepted in current or most recent load
cpu_hold  output  1  processor must stall (its bank is being loaded)

Behaviour:
- Clock and reset: clk is the single clock. reset_n is asynchronous and active-low.
- Reset values: inst=0, inst_valid=0, ld_ready=0, ld_busy=0, ld_count=0, FSM=IDLE. All per-entry written flags are cleared. Memory array contents are not reset, but every entry reads FILL after reset.
- Storage: BANKS×DEPTH words of DATA_W. Each word has one written flag.
- Read: rd_en high at edge N → at edge N+1, inst = written ? mem[rd_bank][rd_addr] : FILL, and inst_valid=1 for that one cycle.
  - If rd_en is low, inst holds its value and inst_valid=0.
  - If rd_bank ≥ BANKS, the read returns FILL.
- Read/write collision: a read and a write to the same bank/address in the same cycle use read-first. The read returns the prior content, or FILL if the entry was unwritten.
- FSM IDLE:
  - ld_ready=0, ld_busy=0.
  - ld_start with ld_bank < BANKS → LOAD. In the same edge: latch the bank, clear all written flags of that bank, set write address=0, set ld_count=0.
  - ld_start with ld_bank ≥ BANKS is ignored; the FSM stays in IDLE.
- FSM LOAD:
  - ld_ready=1, ld_busy=1.
  - A beat transfers when ld_valid && ld_ready. It writes ld_data to mem[bank][addr], sets that entry's written flag, and increments addr and ld_count.
  - Transition to IDLE on the edge that accepts a beat with ld_last=1, or on the edge that accepts the beat at addr=DEPTH-1 (full). ld_ready=0 from the next cycle.
  - Address never wraps. The (DEPTH+1)-th beat is impossible because ld_ready is already low.
  - ld_start during LOAD is ignored.
  - ld_valid low inserts idle cycles with no state change.
- ld_count saturates at DEPTH. It holds its value in IDLE until the next accepted ld_start.
- cpu_hold = ld_busy && (latched load bank == rd_bank). It is combinational on rd_bank. Loading another bank never holds the processor.
- Reset mid-load: the FSM returns to IDLE immediately and all flags are cleared. The partially loaded bank reads FILL.
- Entries beyond the last loaded beat keep their cleared flags and read FILL.

Test Plan:
- Reset, then rd_en with bank 0, addr 5 → the next cycle gives inst=0x00 (FILL) and inst_valid=1.
- Load bank 0 with 12 beats 09,F9,C8,FA,20,C9,DA,20,FA,00,70,B6, with ld_last on the 12th beat → ld_count=12, ld_busy drops. Reads of addr 0..11 return those bytes with one-cycle latency; addr 12..15 return 0x00.
- Load bank 1 with 16 beats 0x10..0x1F and no ld_last → the FSM exits after the 16th beat and ld_ready=0. A 17th ld_valid is not accepted. Bank 0 contents are unchanged.
- Toggle ld_valid during a bank 1 load while rd_bank=1 → cpu_hold=1 throughout LOAD. Switch rd_bank to 0 → cpu_hold=0 and bank 0 reads continue with correct data.
- Assert reset_n=0 after 5 beats into bank 0, then release → all reads return 0x00 and ld_count=0.
- Write addr 3 of bank 0 with 0xAB while reading the same address in the same cycle → the read returns the old value. The next read returns 0xAB.

Source files
------------

// File: rtl/k2_program_memory.sv
// Writable multi-bank program store for the K2 processor: a valid/ready loader
// fills one bank at a time while the CPU fetches from any bank with a one-cycle read.
module k2_program_memory #(
  parameter int                 DATA_W = 8,
  parameter int                 ADDR_W = 4,
  parameter int                 BANKS  = 2,
  parameter logic [DATA_W-1:0]  FILL   = '0,
  localparam int                BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              ld_start,
  input  logic [BANK_W-1:0] ld_bank,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W:0]   ld_count,
  output logic              cpu_hold
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int ENTRIES = BANKS * DEPTH;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t              state;
  logic [BANK_W-1:0]   bank_q;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ENTRIES-1:0]  written;
  logic [DATA_W-1:0]   mem [ENTRIES];

  logic                rd_in_range;
  logic                ld_in_range;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    ld_base;
  logic [IDX_W-1:0]    wr_idx;
  logic                beat;
  logic [DATA_W-1:0]   rd_word;

  // Flat index = bank*DEPTH + addr; the range checks keep out-of-range banks off the array.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_in_range = ({1'b0, rd_bank} < (BANK_W+1)'(BANKS));
    ld_in_range = ({1'b0, ld_bank} < (BANK_W+1)'(BANKS));
    rd_idx      = IDX_W'(rd_bank) * IDX_W'(DEPTH) + IDX_W'(rd_addr);
    ld_base     = IDX_W'(ld_bank) * IDX_W'(DEPTH);
    wr_idx      = IDX_W'(bank_q)  * IDX_W'(DEPTH) + IDX_W'(wr_addr);
    beat        = ld_valid && ld_ready;
    rd_word     = FILL;
    if (rd_in_range && written[rd_idx]) begin
      rd_word = mem[rd_idx];
    end
  end

  assign cpu_hold = ld_busy && (bank_q == rd_bank);

  // NOTE: the storage array has no reset; the written flags alone decide whether
  // an entry is visible, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_idx] <= ld_data;
    end
  end

  // Read-first falls out naturally: rd_word samples mem/flags before this edge's write lands.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= rd_en;
      if (rd_en) begin
        inst <= rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_count <= '0;
      wr_addr  <= '0;
      bank_q   <= '0;
      written  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start && ld_in_range) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
            ld_count <= '0;
            wr_addr  <= '0;
            bank_q   <= ld_bank;
            for (int i = 0; i < DEPTH; i++) begin
              written[ld_base + IDX_W'(i)] <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            written[wr_idx] <= 1'b1;
            if (ld_count != (ADDR_W+1)'(DEPTH)) begin
              ld_count <= ld_count + 1'b1;
            end
            // The last slot ends the load, so the address never needs to wrap.
            if (ld_last || (&wr_addr)) begin
              state    <= IDLE;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k2_program_memory.sv
// Directed bench for k2_program_memory: reset, last/full loads, CPU hold,
// read/write collision and reset in the middle of a load.
module tb_k2_program_memory;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int BANKS  = 2;
  localparam int BANK_W = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rd_en;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              ld_start;
  logic [BANK_W-1:0] ld_bank;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_busy;
  logic [ADDR_W:0]   ld_count;
  logic              cpu_hold;

  int total = 0;
  int bad   = 0;

  logic [7:0] prog0 [12] = '{8'h09, 8'hF9, 8'hC8, 8'hFA, 8'h20, 8'hC9,
                             8'hDA, 8'h20, 8'hFA, 8'h00, 8'h70, 8'hB6};

  k2_program_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .FILL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .inst(inst), .inst_valid(inst_valid),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_count(ld_count),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch: present the request, take one edge, return what the DUT shows after it.
  task automatic do_read(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                         output logic [7:0] d, output logic v);
    rd_en = 1'b1; rd_bank = b; rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = inst; v = inst_valid;
  endtask

  task automatic start_load(input logic [BANK_W-1:0] b);
    ld_start = 1'b1; ld_bank = b;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic v;
    reset_n = 1'b0;
    rd_en = 0; rd_bank = 0; rd_addr = 0;
    ld_start = 0; ld_bank = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total++;
    if ({inst, inst_valid, ld_ready, ld_busy, ld_count, cpu_hold} !== 18'h0) begin
      bad++;
      $display("FAIL reset_values: inst=%h valid=%b ready=%b busy=%b count=%0d hold=%b, want all 0",
               inst, inst_valid, ld_ready, ld_busy, ld_count, cpu_hold);
    end
    do_read(0, 5, d, v);
    total++;
    if (d !== 8'h00 || v !== 1'b1) begin
      bad++;
      $display("FAIL reset_read_fill: inst=%h valid=%b, want 00 1", d, v);
    end
    tick();
    total++;
    if (inst_valid !== 1'b0 || inst !== 8'h00) begin
      bad++;
      $display("FAIL idle_read_hold: inst=%h valid=%b, want 00 0", inst, inst_valid);
    end
  endtask

  task automatic test_load_last();
    logic [7:0] d, exp; logic v;
    start_load(0);
    total++;
    if (ld_busy !== 1'b1 || ld_ready !== 1'b1 || ld_count !== 5'd0) begin
      bad++;
      $display("FAIL load_enter: busy=%b ready=%b count=%0d, want 1 1 0", ld_busy, ld_ready, ld_count);
    end
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1; ld_data = prog0[i]; ld_last = (i == 11);
      tick();
    end
    ld_valid = 0; ld_last = 0;
    total++;
    if (ld_count !== 5'd12 || ld_busy !== 1'b0 || ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_last_exit: count=%0d busy=%b ready=%b, want 12 0 0", ld_count, ld_busy, ld_ready);
    end
    for (int a = 0; a < 16; a++) begin
      exp = (a < 12) ? prog0[a] : 8'h00;
      do_read(0, ADDR_W'(a), d, v);
      total++;
      if (d !== exp || v !== 1'b1) begin
        bad++;
        $display("FAIL bank0_read[%0d]: inst=%h valid=%b, want %h 1", a, d, v, exp);
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] d; logic v;
    start_load(1);
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_data = 8'h10 + 8'(i); ld_last = 1'b0;
      tick();
    end
    total++;
    if (ld_ready !== 1'b0 || ld_busy !== 1'b0 || ld_count !== 5'd16) begin
      bad++;
      $display("FAIL full_exit: ready=%b busy=%b count=%0d, want 0 0 16", ld_ready, ld_busy, ld_count);
    end
    ld_data = 8'hEE;
    tick();
    ld_valid = 1'b0;
    total++;
    if (ld_count !== 5'd16 || ld_busy !== 1'b0) begin
      bad++;
      $display("FAIL beat17_rejected: count=%0d busy=%b, want 16 0", ld_count, ld_busy);
    end
    for (int a = 0; a < 16; a++) begin
      do_read(1, ADDR_W'(a), d, v);
      total++;
      if (d !== 8'h10 + 8'(a)) begin
        bad++;
        $display("FAIL bank1_read[%0d]: inst=%h, want %h", a, d, 8'h10 + 8'(a));
      end
    end
    for (int a = 0; a < 12; a += 5) begin
      do_read(0, ADDR_W'(a), d, v);
      total++;
      if (d !== prog0[a]) begin
        bad++;
        $display("FAIL bank0_kept[%0d]: inst=%h, want %h", a, d, prog0[a]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] d; logic v;
    logic [7:0] beats [3] = '{8'h41, 8'h42, 8'h43};
    int n;
    rd_bank = 1;
    start_load(1);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (cpu_hold !== 1'b1) begin
        bad++;
        $display("FAIL hold_same_bank[%0d]: cpu_hold=%b, want 1", c, cpu_hold);
      end
      ld_valid = c[0];
      ld_data  = beats[n];
      ld_last  = 1'b0;
      // A start pulse in the middle of a load must not retarget it.
      ld_start = (c == 2); ld_bank = 0;
      tick();
      if (c[0]) n++;
    end
    ld_valid = 0; ld_start = 0;
    total++;
    if (ld_count !== 5'd3 || ld_busy !== 1'b1) begin
      bad++;
      $display("FAIL toggle_count: count=%0d busy=%b, want 3 1", ld_count, ld_busy);
    end
    rd_bank = 0;
    #1;
    total++;
    if (cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL hold_other_bank: cpu_hold=%b, want 0", cpu_hold);
    end
    do_read(0, 2, d, v);
    total++;
    if (d !== 8'hC8 || v !== 1'b1) begin
      bad++;
      $display("FAIL read_during_load: inst=%h valid=%b, want c8 1", d, v);
    end
    ld_valid = 1'b1; ld_data = 8'h44; ld_last = 1'b1;
    tick();
    ld_valid = 0; ld_last = 0;
    total++;
    if (ld_busy !== 1'b0 || ld_count !== 5'd4) begin
      bad++;
      $display("FAIL hold_load_exit: busy=%b count=%0d, want 0 4", ld_busy, ld_count);
    end
    do_read(1, 3, d, v);
    total++;
    if (d !== 8'h44) begin
      bad++;
      $display("FAIL bank1_reload[3]: inst=%h, want 44", d);
    end
    do_read(1, 4, d, v);
    total++;
    if (d !== 8'h00) begin
      bad++;
      $display("FAIL bank1_cleared[4]: inst=%h, want 00", d);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d; logic v;
    logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'hAB};
    start_load(0);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = beats[i]; ld_last = (i == 3);
      if (i == 3) begin
        rd_en = 1'b1; rd_bank = 0; rd_addr = 3;
      end
      tick();
    end
    rd_en = 0; ld_valid = 0; ld_last = 0;
    total++;
    if (inst !== 8'h00 || inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL collision_read_first: inst=%h valid=%b, want 00 1", inst, inst_valid);
    end
    do_read(0, 3, d, v);
    total++;
    if (d !== 8'hAB) begin
      bad++;
      $display("FAIL collision_after: inst=%h, want ab", d);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] d; logic v;
    start_load(0);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 8'h60 + 8'(i); ld_last = 1'b0;
      tick();
    end
    ld_valid = 0;
    reset_n = 1'b0;
    #1;
    total++;
    if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || ld_count !== 5'd0) begin
      bad++;
      $display("FAIL async_reset: busy=%b ready=%b count=%0d, want 0 0 0", ld_busy, ld_ready, ld_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) begin
      do_read(0, ADDR_W'(a), d, v);
      total++;
      if (d !== 8'h00) begin
        bad++;
        $display("FAIL reset_bank0[%0d]: inst=%h, want 00", a, d);
      end
    end
    do_read(1, 0, d, v);
    total++;
    if (d !== 8'h00 || ld_count !== 5'd0) begin
      bad++;
      $display("FAIL reset_bank1: inst=%h count=%0d, want 00 0", d, ld_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_last();
    test_full();
    test_hold();
    test_collision();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
